// File: rtl/phase_4.sv
// Post-adder/subtractor and output stage: P = Z +/- (X + CIN), with P, CARRYOUT and CYI registers.
// Optional sticky signed-overflow flag compiled in with `define PHASE4_OVF_EN.
module phase_4 #(
  parameter int unsigned CARRYINREG  = 1,
  parameter int unsigned PREG        = 1,
  parameter int unsigned CARRYOUTREG = 1,
  parameter string       CARRYINSEL  = "OPMODE5",
  parameter int unsigned C_WIDTH     = 48
) (
  input  logic               clk,
  input  logic               rstp,
  input  logic               cep,
  input  logic               cecarryin,
  input  logic [C_WIDTH-1:0] mux_x_out,
  input  logic [C_WIDTH-1:0] mux_z_out,
  input  logic               opmode_5,
  input  logic               opmode_7,
  input  logic               carryin,
  output logic [C_WIDTH-1:0] P,
  output logic [C_WIDTH-1:0] PCOUT,
  output logic               CARRYOUT,
  output logic               CARRYOUTF,
  output logic               ovf
);

  logic               cyi_sel;
  logic               cin;
  logic [C_WIDTH:0]   sum;
  logic [C_WIDTH-1:0] p_d;
  logic               co_d;

  // Carry-in source select; unknown selector values force a zero carry.
  generate
    if (CARRYINSEL == "OPMODE5") begin : g_sel_op5
      assign cyi_sel = opmode_5;
    end else if (CARRYINSEL == "CARRYIN") begin : g_sel_cin
      assign cyi_sel = carryin;
    end else begin : g_sel_zero
      assign cyi_sel = 1'b0;
    end
  endgenerate

  generate
    if (CARRYINREG != 0) begin : g_cyi_reg
      logic cyi_q;
      always_ff @(posedge clk) begin
        if (rstp) begin
          cyi_q <= 1'b0;
        end else if (cecarryin) begin
          cyi_q <= cyi_sel;
        end
      end
      assign cin = cyi_q;
    end else begin : g_cyi_wire
      assign cin = cyi_sel;
    end
  endgenerate

  // Zero-extended by one bit so the top bit is carry on add and borrow on subtract.
  always_comb begin
    sum = '0;
    if (opmode_7) begin
      sum = {1'b0, mux_z_out} - ({1'b0, mux_x_out} + {{C_WIDTH{1'b0}}, cin});
    end else begin
      sum = {1'b0, mux_z_out} + {1'b0, mux_x_out} + {{C_WIDTH{1'b0}}, cin};
    end
  end

  assign p_d  = sum[C_WIDTH-1:0];
  assign co_d = sum[C_WIDTH];

  generate
    if (PREG != 0) begin : g_p_reg
      logic [C_WIDTH-1:0] p_q;
      always_ff @(posedge clk) begin
        if (rstp) begin
          p_q <= '0;
        end else if (cep) begin
          p_q <= p_d;
        end
      end
      assign P = p_q;
    end else begin : g_p_wire
      assign P = p_d;
    end
  endgenerate

  generate
    if (CARRYOUTREG != 0) begin : g_co_reg
      logic co_q;
      always_ff @(posedge clk) begin
        if (rstp) begin
          co_q <= 1'b0;
        end else if (cep) begin
          co_q <= co_d;
        end
      end
      assign CARRYOUT = co_q;
    end else begin : g_co_wire
      assign CARRYOUT = co_d;
    end
  endgenerate

  assign PCOUT     = P;
  assign CARRYOUTF = CARRYOUT;

`ifdef PHASE4_OVF_EN
  logic ovf_hit;
  logic ovf_q;

  always_comb begin
    ovf_hit = 1'b0;
    if (opmode_7) begin
      ovf_hit = (mux_x_out[C_WIDTH-1] != mux_z_out[C_WIDTH-1]) &&
                (sum[C_WIDTH-1] != mux_z_out[C_WIDTH-1]);
    end else begin
      ovf_hit = (mux_x_out[C_WIDTH-1] == mux_z_out[C_WIDTH-1]) &&
                (sum[C_WIDTH-1] != mux_z_out[C_WIDTH-1]);
    end
  end

  // Sticky: only rstp clears it.
  always_ff @(posedge clk) begin
    if (rstp) begin
      ovf_q <= 1'b0;
    end else if (cep && ovf_hit) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_phase_4.sv
// Self-checking bench for phase_4 (default parameters): directed scenarios plus randomized
// traffic checked against an arithmetic reference model.
module tb_phase_4;

`ifdef PHASE4_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic        clk;
  logic        rstp, cep, cecarryin, opmode_5, opmode_7, carryin;
  logic [47:0] x_drv, z_drv, mux_x_out, mux_z_out, P, PCOUT;
  logic        CARRYOUT, CARRYOUTF, ovf;
  logic        z_fb;

  // Reference model state
  logic [47:0] p_m;
  logic        co_m, cyi_m, ovf_m;

  int checks = 0;
  int errors = 0;

  assign mux_x_out = x_drv;
  assign mux_z_out = z_fb ? PCOUT : z_drv;

  phase_4 dut (
    .clk       (clk),
    .rstp      (rstp),
    .cep       (cep),
    .cecarryin (cecarryin),
    .mux_x_out (mux_x_out),
    .mux_z_out (mux_z_out),
    .opmode_5  (opmode_5),
    .opmode_7  (opmode_7),
    .carryin   (carryin),
    .P         (P),
    .PCOUT     (PCOUT),
    .CARRYOUT  (CARRYOUT),
    .CARRYOUTF (CARRYOUTF),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; the model evaluates the inputs present before the edge.
  task automatic cycle();
    longint unsigned x, z, s, t;
    logic [47:0] pn;
    logic        con, ovc;
    x = 64'(x_drv);
    z = z_fb ? 64'(p_m) : 64'(z_drv);
    if (!opmode_7) begin
      s   = z + x + 64'(cyi_m);
      con = s[48];
    end else begin
      t   = x + 64'(cyi_m);
      con = (z < t);
      s   = z - t;
    end
    pn = s[47:0];
    if (!opmode_7) ovc = (x[47] == z[47]) && (pn[47] != z[47]);
    else           ovc = (x[47] != z[47]) && (pn[47] != z[47]);
    @(posedge clk);
    #1;
    if (rstp) begin
      p_m = '0; co_m = 1'b0; cyi_m = 1'b0; ovf_m = 1'b0;
    end else begin
      if (cep) begin
        p_m = pn; co_m = con; ovf_m = ovf_m | ovc;
      end
      if (cecarryin) cyi_m = opmode_5;
    end
  endtask

  task automatic test_reset();
    rstp = 1'b1; cep = 1'b1; cecarryin = 1'b1; x_drv = 48'd5; z_drv = 48'd7;
    opmode_5 = 1'b1; opmode_7 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (P !== 48'd0) begin
        errors++; $display("FAIL reset_p cyc%0d: got %h want 0", i, P);
      end
      checks++;
      if (CARRYOUT !== 1'b0 || ovf !== 1'b0) begin
        errors++; $display("FAIL reset_co_ovf cyc%0d: got co=%b ovf=%b want 0 0", i, CARRYOUT, ovf);
      end
    end
  endtask

  task automatic test_add_carry();
    rstp = 1'b0; opmode_5 = 1'b1; x_drv = '0; z_drv = '0;
    cycle();
    x_drv = 48'd5; z_drv = 48'd7; opmode_7 = 1'b0;
    cycle();
    checks++;
    if (P !== 48'd13 || CARRYOUT !== 1'b0) begin
      errors++; $display("FAIL add_carry: got p=%0d co=%b want 13 0", P, CARRYOUT);
    end
  endtask

  task automatic test_sub();
    opmode_5 = 1'b0;
    cycle();
    z_drv = 48'd100; x_drv = 48'd30; opmode_7 = 1'b1;
    cycle();
    checks++;
    if (P !== 48'd70 || CARRYOUT !== 1'b0) begin
      errors++; $display("FAIL sub_pos: got p=%0d co=%b want 70 0", P, CARRYOUT);
    end
    z_drv = 48'd10;
    cycle();
    checks++;
    if (P !== 48'hFFFF_FFFF_FFEC || CARRYOUT !== 1'b1) begin
      errors++; $display("FAIL sub_borrow: got p=%h co=%b want ffffffffffec 1", P, CARRYOUT);
    end
  endtask

  task automatic test_carryout();
    x_drv = 48'hFFFF_FFFF_FFFF; z_drv = 48'hFFFF_FFFF_FFFF; opmode_7 = 1'b0;
    cycle();
    checks++;
    if (P !== 48'hFFFF_FFFF_FFFE || PCOUT !== 48'hFFFF_FFFF_FFFE) begin
      errors++; $display("FAIL carry_p: got p=%h pcout=%h want fffffffffffe", P, PCOUT);
    end
    checks++;
    if (CARRYOUT !== 1'b1 || CARRYOUTF !== 1'b1) begin
      errors++; $display("FAIL carry_co: got co=%b cof=%b want 1 1", CARRYOUT, CARRYOUTF);
    end
  endtask

  task automatic test_accumulate();
    rstp = 1'b1;
    cycle();
    rstp = 1'b0; z_fb = 1'b1; x_drv = 48'd3; opmode_7 = 1'b0; opmode_5 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (P !== 48'(3 * k)) begin
        errors++; $display("FAIL accum_step%0d: got %0d want %0d", k, P, 3 * k);
      end
    end
    cep = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (P !== 48'd12) begin
        errors++; $display("FAIL accum_hold%0d: got %0d want 12", k, P);
      end
    end
    rstp = 1'b1;
    cycle();
    checks++;
    if (P !== 48'd0) begin
      errors++; $display("FAIL accum_reset: got %0d want 0", P);
    end
    rstp = 1'b0; cep = 1'b1;
    cycle();
    checks++;
    if (P !== 48'd3) begin
      errors++; $display("FAIL accum_restart: got %0d want 3", P);
    end
    z_fb = 1'b0;
  endtask

  task automatic test_overflow();
    rstp = 1'b1;
    cycle();
    rstp = 1'b0; z_drv = 48'h7FFF_FFFF_FFFF; x_drv = 48'd1; opmode_7 = 1'b0;
    cycle();
    checks++;
    if (P !== 48'h8000_0000_0000 || ovf !== OvfEn) begin
      errors++; $display("FAIL ovf_set: got p=%h ovf=%b want 800000000000 %b", P, ovf, OvfEn);
    end
    z_drv = 48'd2;
    cycle();
    checks++;
    if (P !== 48'd3 || ovf !== OvfEn) begin
      errors++; $display("FAIL ovf_sticky: got p=%0d ovf=%b want 3 %b", P, ovf, OvfEn);
    end
    rstp = 1'b1;
    cycle();
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", ovf);
    end
    rstp = 1'b0;
  endtask

  function automatic logic [47:0] pick_operand();
    logic [47:0] v;
    case ($urandom_range(0, 5))
      0:       v = 48'h0;
      1:       v = 48'hFFFF_FFFF_FFFF;
      2:       v = 48'h7FFF_FFFF_FFFF;
      3:       v = 48'h8000_0000_0000;
      default: v = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    endcase
    return v;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rstp      = ($urandom_range(0, 19) == 0);
      cep       = ($urandom_range(0, 3) != 0);
      cecarryin = ($urandom_range(0, 3) != 0);
      opmode_5  = 1'($urandom());
      opmode_7  = 1'($urandom());
      carryin   = 1'($urandom());
      z_fb      = ($urandom_range(0, 3) == 0);
      x_drv     = pick_operand();
      z_drv     = pick_operand();
      cycle();
      checks++;
      if (P !== p_m || PCOUT !== p_m) begin
        errors++; $display("FAIL rand_p it%0d: got p=%h pcout=%h want %h", i, P, PCOUT, p_m);
      end
      checks++;
      if (CARRYOUT !== co_m || CARRYOUTF !== co_m) begin
        errors++; $display("FAIL rand_co it%0d: got co=%b cof=%b want %b", i, CARRYOUT, CARRYOUTF, co_m);
      end
      checks++;
      if (ovf !== (ovf_m & OvfEn)) begin
        errors++; $display("FAIL rand_ovf it%0d: got %b want %b", i, ovf, ovf_m & OvfEn);
      end
    end
    z_fb = 1'b0;
  endtask

  initial begin
    rstp = 1'b1; cep = 1'b1; cecarryin = 1'b1; opmode_5 = 1'b0; opmode_7 = 1'b0;
    carryin = 1'b0; x_drv = '0; z_drv = '0; z_fb = 1'b0;
    p_m = '0; co_m = 1'b0; cyi_m = 1'b0; ovf_m = 1'b0;
    test_reset();
    test_add_carry();
    test_sub();
    test_carryout();
    test_accumulate();
    test_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
